// File: rtl/sar_pkg.sv
// Shared types and default sizing for the successive-approximation sequencer.
package sar_pkg;

    localparam int NBITS         = 6;
    localparam int SAMPLE_CYCLES = 4;
    localparam int SETTLE_CYCLES = 2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SAMPLE,
        ST_SETTLE,
        ST_DECIDE,
        ST_STROBE,
        ST_HOLD
    } sar_state_t;

    // The timer must be able to hold max(SAMPLE_CYCLES, SETTLE_CYCLES) - 1.
    function automatic int timer_width(input int a, input int b);
        int m;
        m = (a > b) ? a : b;
        return (m <= 2) ? 1 : $clog2(m);
    endfunction

    localparam int TIMER_W = timer_width(SAMPLE_CYCLES, SETTLE_CYCLES);

endpackage

// File: rtl/sar_seq_if.sv
// Conversion request, comparator/DAC and result handshake signals of the sequencer.
interface sar_seq_if #(
    parameter int NBITS = sar_pkg::NBITS
);
    logic             start;
    logic             cmp;
    logic             sample;
    logic [NBITS-1:0] trial;
    logic             rs;
    logic             busy;
    logic [NBITS-1:0] dout;
    logic             dout_valid;
    logic             dout_ready;

    modport slave (
        input  start, cmp, dout_ready,
        output sample, trial, rs, busy, dout, dout_valid
    );

    modport master (
        output start, cmp, dout_ready,
        input  sample, trial, rs, busy, dout, dout_valid
    );
endinterface

// File: rtl/sar_timer.sv
// Loadable saturating down-counter, shared by the sample and settle phases.
module sar_timer #(
    parameter int W = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic [W-1:0] value,
    output logic         zero
);

    logic [W-1:0] value_q;
    logic [W-1:0] value_d;

    always_comb begin
        value_d = value_q;
        if (load) begin
            value_d = load_val;
        end else if (value_q != '0) begin
            value_d = value_q - W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            value_q <= '0;
        end else begin
            value_q <= value_d;
        end
    end

    assign value = value_q;
    assign zero  = (value_q == '0);

endmodule

// File: rtl/sar_seq.sv
// Successive-approximation conversion sequencer: sample phase, MSB-first bit
// trials against the comparator, result strobe and valid/ready output stage.
module sar_seq
    import sar_pkg::*;
#(
    parameter int NBITS         = sar_pkg::NBITS,
    parameter int SAMPLE_CYCLES = sar_pkg::SAMPLE_CYCLES,
    parameter int SETTLE_CYCLES = sar_pkg::SETTLE_CYCLES
) (
    input  logic      clk,
    input  logic      rst,
    sar_seq_if.slave  bus
);

    localparam int TW    = timer_width(SAMPLE_CYCLES, SETTLE_CYCLES);
    localparam int IDX_W = (NBITS > 1) ? $clog2(NBITS) : 1;

    localparam logic [TW-1:0]    SAMPLE_LOAD = TW'(SAMPLE_CYCLES - 1);
    localparam logic [TW-1:0]    SETTLE_LOAD = TW'(SETTLE_CYCLES - 1);
    localparam logic [IDX_W-1:0] IDX_TOP     = IDX_W'(NBITS - 1);

    sar_state_t       state_q, state_d;
    logic [NBITS-1:0] trial_q, trial_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [NBITS-1:0] dout_q, dout_d;
    logic             sample_q, rs_q, busy_q, dout_valid_q;

    logic             tmr_load;
    logic [TW-1:0]    tmr_load_val;
    logic [TW-1:0]    tmr_value;
    logic             tmr_zero;
    logic             unused_tmr;

    sar_timer #(.W(TW)) u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (tmr_load),
        .load_val (tmr_load_val),
        .value    (tmr_value),
        .zero     (tmr_zero)
    );

    assign unused_tmr = ^tmr_value;

    always_comb begin
        state_d      = state_q;
        trial_d      = trial_q;
        idx_d        = idx_q;
        dout_d       = dout_q;
        tmr_load     = 1'b0;
        tmr_load_val = SAMPLE_LOAD;

        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    state_d  = ST_SAMPLE;
                    tmr_load = 1'b1;
                    trial_d  = '0;
                end
            end
            ST_SAMPLE: begin
                if (tmr_zero) begin
                    state_d             = ST_SETTLE;
                    idx_d               = IDX_TOP;
                    trial_d             = '0;
                    trial_d[NBITS-1]    = 1'b1;
                    tmr_load            = 1'b1;
                    tmr_load_val        = SETTLE_LOAD;
                end
            end
            ST_SETTLE: begin
                if (tmr_zero) begin
                    state_d = ST_DECIDE;
                end
            end
            ST_DECIDE: begin
                if (!bus.cmp) begin
                    trial_d[idx_q] = 1'b0;
                end
                if (idx_q == '0) begin
                    state_d = ST_STROBE;
                    // Result lands in dout on the same edge that raises rs.
                    dout_d  = trial_d;
                end else begin
                    state_d                     = ST_SETTLE;
                    idx_d                       = idx_q - IDX_W'(1);
                    trial_d[idx_q - IDX_W'(1)]  = 1'b1;
                    tmr_load                    = 1'b1;
                    tmr_load_val                = SETTLE_LOAD;
                end
            end
            ST_STROBE: begin
                state_d = ST_HOLD;
            end
            ST_HOLD: begin
                if (bus.dout_ready) begin
                    if (bus.start) begin
                        state_d  = ST_SAMPLE;
                        tmr_load = 1'b1;
                        trial_d  = '0;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // The sample phase also clears the quantizer output register.
        if (state_d == ST_SAMPLE) begin
            dout_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= ST_IDLE;
            trial_q      <= '0;
            idx_q        <= '0;
            dout_q       <= '0;
            sample_q     <= 1'b0;
            rs_q         <= 1'b0;
            busy_q       <= 1'b0;
            dout_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            trial_q      <= trial_d;
            idx_q        <= idx_d;
            dout_q       <= dout_d;
            sample_q     <= (state_d == ST_SAMPLE);
            rs_q         <= (state_d == ST_STROBE);
            busy_q       <= (state_d != ST_IDLE);
            dout_valid_q <= (state_d == ST_HOLD);
        end
    end

    assign bus.sample     = sample_q;
    assign bus.trial      = trial_q;
    assign bus.rs         = rs_q;
    assign bus.busy       = busy_q;
    assign bus.dout       = dout_q;
    assign bus.dout_valid = dout_valid_q;

endmodule

// File: tb/tb_sar_seq.sv
// Bench for sar_seq: comparator model cmp = (vin >= trial), reference SAR search
// computed arithmetically, one task per scenario.
module tb_sar_seq;
    import sar_pkg::*;

    localparam int NB  = 6;
    localparam int SC  = 4;
    localparam int TC  = 2;
    localparam int LAT = SC + NB * (TC + 1) + 1;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    int vin      = 0;
    int cmp_mode = 0;   // 0: analog model, 1: tied high, 2: tied low
    int errors   = 0;
    int checks   = 0;

    int obs_trials[$];
    int exp_trials[$];

    sar_seq_if #(.NBITS(NB)) bus ();

    assign bus.cmp = (cmp_mode == 1) ? 1'b1 :
                     (cmp_mode == 2) ? 1'b0 :
                     (vin >= int'(bus.trial));

    sar_seq #(.NBITS(NB), .SAMPLE_CYCLES(SC), .SETTLE_CYCLES(TC)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Binary search over the code space, recording every trial code presented.
    function automatic int sar_ref(input int v, input int mode);
        int code;
        int t;
        bit c;
        code = 0;
        exp_trials.delete();
        for (int b = NB - 1; b >= 0; b--) begin
            t = code + (1 << b);
            exp_trials.push_back(t);
            c = (mode == 1) ? 1'b1 : (mode == 2) ? 1'b0 : (v >= t);
            if (c) code = t;
        end
        if (code != exp_trials[exp_trials.size()-1]) exp_trials.push_back(code);
        return code;
    endfunction

    // Observe one conversion whose start was sampled at the previous edge.
    task automatic measure(input bit hold_start, output int lat, output int n_sample,
                           output bit sample_contig, output int n_rs, output int rs_at,
                           output logic [NB-1:0] dout_at_rs);
        int n;
        logic [NB-1:0] prev;
        n = 0; lat = -1; n_sample = 0; sample_contig = 1'b1;
        n_rs = 0; rs_at = -1; dout_at_rs = '0; prev = '0;
        obs_trials.delete();
        while (n < 200) begin
            @(negedge clk);
            bus.start = hold_start;
            if (bus.sample) begin
                n_sample++;
                if (n >= SC) sample_contig = 1'b0;
            end else if (n < SC) begin
                sample_contig = 1'b0;
            end
            if (bus.rs) begin
                n_rs++;
                rs_at = n;
                dout_at_rs = bus.dout;
            end
            if (bus.busy && !bus.sample && bus.trial !== prev) obs_trials.push_back(int'(bus.trial));
            prev = bus.trial;
            if (bus.dout_valid) begin
                lat = n;
                break;
            end
            n++;
        end
        $display("conv vin=%0d mode=%0d dout=%0d latency=%0d", vin, cmp_mode, bus.dout, lat);
    endtask

    task automatic test_reset();
        checks++;
        if ({bus.sample, bus.rs, bus.busy, bus.dout_valid, bus.trial, bus.dout} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got %b, want all zero",
                     {bus.sample, bus.rs, bus.busy, bus.dout_valid, bus.trial, bus.dout});
        end
        @(negedge clk); rst = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if ({bus.sample, bus.busy, bus.dout_valid} !== 3'b000) begin
            errors++;
            $display("FAIL reset_idle: sample/busy/valid=%b, want 000",
                     {bus.sample, bus.busy, bus.dout_valid});
        end
    endtask

    task automatic test_basic();
        int lat, ns, nrs, rsat, exp;
        bit contig, tr_ok;
        logic [NB-1:0] drs;
        vin = 43; cmp_mode = 0; bus.dout_ready = 1'b1;
        exp = sar_ref(vin, cmp_mode);
        @(negedge clk); bus.start = 1'b1;
        measure(1'b0, lat, ns, contig, nrs, rsat, drs);
        bus.start = 1'b0;
        checks++;
        if (bus.dout !== NB'(exp)) begin errors++; $display("FAIL basic_dout: got %0d, want %0d", bus.dout, exp); end
        checks++;
        if (lat !== LAT) begin errors++; $display("FAIL basic_latency: got %0d, want %0d", lat, LAT); end
        checks++;
        if (ns !== SC || !contig) begin errors++; $display("FAIL basic_sample: cycles=%0d contiguous=%0d, want %0d/1", ns, contig, SC); end
        checks++;
        if (nrs !== 1 || rsat !== LAT - 1 || drs !== NB'(exp)) begin
            errors++;
            $display("FAIL basic_rs: pulses=%0d at=%0d dout=%0d, want 1 at %0d dout=%0d", nrs, rsat, drs, LAT - 1, exp);
        end
        tr_ok = (obs_trials.size() == exp_trials.size());
        if (tr_ok) foreach (exp_trials[i]) if (obs_trials[i] != exp_trials[i]) tr_ok = 1'b0;
        checks++;
        if (!tr_ok) begin errors++; $display("FAIL basic_trials: got %p, want %p", obs_trials, exp_trials); end
        @(negedge clk);
        checks++;
        if ({bus.busy, bus.dout_valid} !== 2'b00) begin
            errors++;
            $display("FAIL basic_to_idle: busy/valid=%b, want 00", {bus.busy, bus.dout_valid});
        end
    endtask

    task automatic test_tied();
        int lat, ns, nrs, rsat, exp;
        bit contig;
        logic [NB-1:0] drs;
        for (int m = 1; m <= 2; m++) begin
            cmp_mode = m; vin = 0; bus.dout_ready = 1'b1;
            exp = sar_ref(vin, m);
            @(negedge clk); bus.start = 1'b1;
            measure(1'b0, lat, ns, contig, nrs, rsat, drs);
            bus.start = 1'b0;
            checks++;
            if (bus.dout !== NB'(exp)) begin errors++; $display("FAIL tied%0d_dout: got %0d, want %0d", m, bus.dout, exp); end
            checks++;
            if (nrs !== 1 || rsat !== LAT - 1) begin
                errors++;
                $display("FAIL tied%0d_rs: pulses=%0d at=%0d, want 1 at %0d", m, nrs, rsat, LAT - 1);
            end
            @(negedge clk);
        end
        cmp_mode = 0;
    endtask

    task automatic test_stall();
        int lat, ns, nrs, rsat;
        bit contig, stable;
        logic [NB-1:0] drs;
        vin = 20; bus.dout_ready = 1'b0;
        @(negedge clk); bus.start = 1'b1;
        measure(1'b0, lat, ns, contig, nrs, rsat, drs);
        bus.start = 1'b0;
        checks++;
        if (bus.dout !== NB'(sar_ref(vin, 0))) begin errors++; $display("FAIL stall_dout: got %0d, want %0d", bus.dout, vin); end
        stable = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            bus.start = (i == 4);
            if (bus.dout !== NB'(vin) || bus.dout_valid !== 1'b1 || bus.sample !== 1'b0 || bus.rs !== 1'b0) stable = 1'b0;
        end
        bus.start = 1'b0;
        checks++;
        if (!stable) begin errors++; $display("FAIL stall_hold: dout=%0d valid=%0d sample=%0d, want %0d/1/0", bus.dout, bus.dout_valid, bus.sample, vin); end
        bus.dout_ready = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if ({bus.busy, bus.dout_valid, bus.sample} !== 3'b000) begin
            errors++;
            $display("FAIL stall_release: busy/valid/sample=%b, want 000", {bus.busy, bus.dout_valid, bus.sample});
        end
    endtask

    task automatic test_reset_mid();
        int lat, ns, nrs, rsat;
        bit contig;
        logic [NB-1:0] drs;
        vin = 50; bus.dout_ready = 1'b1;
        @(negedge clk); bus.start = 1'b1;
        // Negedges 0..10 after the start edge; negedge 10 falls in the third settle.
        for (int n = 0; n <= 10; n++) begin
            @(negedge clk);
            bus.start = 1'b0;
        end
        checks++;
        if (bus.trial !== 6'd56 || bus.busy !== 1'b1) begin
            errors++;
            $display("FAIL midconv_trial: trial=%0d busy=%0d, want 56/1", bus.trial, bus.busy);
        end
        rst = 1'b0;
        #1;
        checks++;
        if ({bus.sample, bus.rs, bus.busy, bus.dout_valid, bus.trial, bus.dout} !== '0) begin
            errors++;
            $display("FAIL async_reset: got %b, want all zero",
                     {bus.sample, bus.rs, bus.busy, bus.dout_valid, bus.trial, bus.dout});
        end
        repeat (2) @(negedge clk);
        rst = 1'b1;
        vin = 7;
        @(negedge clk); bus.start = 1'b1;
        measure(1'b0, lat, ns, contig, nrs, rsat, drs);
        bus.start = 1'b0;
        checks++;
        if (bus.dout !== NB'(sar_ref(vin, 0)) || lat !== LAT) begin
            errors++;
            $display("FAIL post_reset_conv: dout=%0d latency=%0d, want 7/%0d", bus.dout, lat, LAT);
        end
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        int lat, ns, nrs, rsat;
        bit contig;
        logic [NB-1:0] drs;
        vin = 63; bus.dout_ready = 1'b0;
        @(negedge clk); bus.start = 1'b1;
        measure(1'b0, lat, ns, contig, nrs, rsat, drs);
        checks++;
        if (bus.dout !== NB'(sar_ref(vin, 0))) begin errors++; $display("FAIL b2b_first: got %0d, want 63", bus.dout); end
        bus.start = 1'b1; bus.dout_ready = 1'b1; vin = 1;
        measure(1'b0, lat, ns, contig, nrs, rsat, drs);
        bus.start = 1'b0;
        checks++;
        if (ns !== SC || !contig) begin errors++; $display("FAIL b2b_no_gap: sample cycles=%0d contiguous=%0d, want %0d/1", ns, contig, SC); end
        checks++;
        if (bus.dout !== NB'(sar_ref(vin, 0)) || lat !== LAT) begin
            errors++;
            $display("FAIL b2b_second: dout=%0d latency=%0d, want 1/%0d", bus.dout, lat, LAT);
        end
        @(negedge clk);
    endtask

    task automatic test_start_held();
        int lat, ns, nrs, rsat;
        bit contig;
        logic [NB-1:0] drs;
        vin = 37; bus.dout_ready = 1'b1;
        @(negedge clk); bus.start = 1'b1;
        measure(1'b1, lat, ns, contig, nrs, rsat, drs);
        bus.start = 1'b0;
        checks++;
        if (lat !== LAT || ns !== SC || !contig || nrs !== 1) begin
            errors++;
            $display("FAIL start_held: latency=%0d sample=%0d rs=%0d, want %0d/%0d/1", lat, ns, nrs, LAT, SC);
        end
        checks++;
        if (bus.dout !== NB'(sar_ref(vin, 0))) begin errors++; $display("FAIL start_held_dout: got %0d, want %0d", bus.dout, vin); end
        @(negedge clk);
    endtask

    task automatic test_random();
        int lat, ns, nrs, rsat, stall, exp;
        bit contig;
        logic [NB-1:0] drs;
        for (int k = 0; k < 8; k++) begin
            vin = int'($urandom_range(0, 63));
            stall = int'($urandom_range(0, 3));
            exp = sar_ref(vin, 0);
            bus.dout_ready = (stall == 0);
            @(negedge clk); bus.start = 1'b1;
            measure(1'b0, lat, ns, contig, nrs, rsat, drs);
            bus.start = 1'b0;
            if (stall > 0) begin
                repeat (stall) @(negedge clk);
                bus.dout_ready = 1'b1;
            end
            checks++;
            if (bus.dout !== NB'(exp) || lat !== LAT) begin
                errors++;
                $display("FAIL random_%0d: vin=%0d dout=%0d latency=%0d, want %0d/%0d", k, vin, bus.dout, lat, exp, LAT);
            end
            @(negedge clk);
        end
    endtask

    initial begin
        bus.start = 1'b0;
        bus.dout_ready = 1'b1;
        #2;
        test_reset();
        test_basic();
        test_tied();
        test_stall();
        test_reset_mid();
        test_back_to_back();
        test_start_held();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
